hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It extends the combinational hazard logic with three additions:
- a multi-cycle MUL/DIV occupancy counter that freezes the front of the pipeline;
- a data-memory wait handshake that freezes the whole pipeline;
- saturating stall/flush performance counters.

Forwarding selects, load-use interlock and branch flushing keep the existing encodings. Forwarding can be disabled by parameter, in which case hazards are resolved by interlock.

---
 rtl/hazard_ctrl_if.sv | 55 +++++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline register/control taps in,
// stall/flush/forward controls and perf counters out.
interface hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] Rs1D;
   logic [REG_W-1:0] Rs2D;
   logic [REG_W-1:0] Rs1E;
   logic [REG_W-1:0] Rs2E;
   logic [REG_W-1:0] RdE;
   logic [REG_W-1:0] RdM;
   logic [REG_W-1:0] RdW;
   logic             ResultSrcE0;
   logic             RegWriteE;
   logic             RegWriteM;
   logic             RegWriteW;
   logic             PCSrcE;
   logic             MduStartE;
   logic             MemReadyM;
   logic             CntClr;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushM;
   logic             FlushW;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             MduBusy;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output ResultSrcE0, RegWriteE, RegWriteM, RegWriteW,
      output PCSrcE, MduStartE, MemReadyM, CntClr,
      input  StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushM, FlushW,
      input  ForwardAE, ForwardBE, MduBusy,
      input  StallCount, FlushCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  ResultSrcE0, RegWriteE, RegWriteM, RegWriteW,
      input  PCSrcE, MduStartE, MemReadyM, CntClr,
      output StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushM, FlushW,
      output ForwardAE, ForwardBE, MduBusy,
      output StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, interlocks, branch flush,
// MDU occupancy freeze, mem-wait freeze and stall/flush counters.
module hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int MDU_LATENCY = 4,
   parameter int FWD_EN      = 1,
   parameter int CNT_W       = 16
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);
   localparam int MW = $clog2(MDU_LATENCY) + 1;
   localparam logic [MW-1:0] MDU_LOAD = MW'(MDU_LATENCY - 1);
   localparam bit MULTI = (MDU_LATENCY > 1);

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rdm,
      input logic [REG_W-1:0] rdw,
      input logic             wm,
      input logic             ww
   );
      if (rs != '0 && rs == rdm && wm) return 2'b10;
      if (rs != '0 && rs == rdw && ww) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic raw_hit(
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rde,
      input logic [REG_W-1:0] rdm,
      input logic [REG_W-1:0] rdw,
      input logic             we,
      input logic             wm,
      input logic             ww
   );
      return (rs != '0) &&
             ((rs == rde && we) ||
              (rs == rdm && wm) ||
              (rs == rdw && ww));
   endfunction

   logic [MW-1:0]    mdu_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic mem_wait;
   logic mdu_start;
   logic freeze;
   logic load_use;
   logic raw;
   logic sel_mem, sel_mdu, sel_br, sel_int;
   logic stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_m, flush_w;
   logic busy;
   logic [1:0] fwd_a, fwd_b;

   always_comb begin
      mem_wait  = ~hz.MemReadyM;
      mdu_start = MULTI && hz.MduStartE && (mdu_cnt == '0);
      freeze    = mdu_start || (mdu_cnt > MW'(1));
      load_use  = hz.ResultSrcE0 && (hz.RdE != '0) &&
                  (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
      raw       = (FWD_EN == 0) &&
                  (raw_hit(hz.Rs1D, hz.RdE, hz.RdM, hz.RdW,
                           hz.RegWriteE, hz.RegWriteM, hz.RegWriteW) ||
                   raw_hit(hz.Rs2D, hz.RdE, hz.RdM, hz.RdW,
                           hz.RegWriteE, hz.RegWriteM, hz.RegWriteW));
      // one-hot priority selects so the decoder stays unique
      sel_mem = mem_wait;
      sel_mdu = !mem_wait && freeze;
      sel_br  = !mem_wait && !freeze && hz.PCSrcE;
      sel_int = !mem_wait && !freeze && !hz.PCSrcE &&
                (load_use || raw);
   end

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
      busy    = 1'b0;
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
      if (rst_n) begin
         unique case (1'b1)
            sel_mem: begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
            end
            sel_mdu: begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
            end
            sel_br: begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end
            sel_int: begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
            default: ;
         endcase
         busy = freeze;
         if (FWD_EN != 0) begin
            fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW,
                            hz.RegWriteM, hz.RegWriteW);
            fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW,
                            hz.RegWriteM, hz.RegWriteW);
         end
      end
   end

   // mem wait holds the count so a stalled freeze is extended
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdu_cnt <= '0;
      end else if (!mem_wait) begin
         if (mdu_start)
            mdu_cnt <= MDU_LOAD;
         else if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - MW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (hz.CntClr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_d && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign hz.StallF     = stall_f;
   assign hz.StallD     = stall_d;
   assign hz.StallE     = stall_e;
   assign hz.StallM     = stall_m;
   assign hz.FlushD     = flush_d;
   assign hz.FlushE     = flush_e;
   assign hz.FlushM     = flush_m;
   assign hz.FlushW     = flush_w;
   assign hz.ForwardAE  = fwd_a;
   assign hz.ForwardBE  = fwd_b;
   assign hz.MduBusy    = busy;
   assign hz.StallCount = stall_cnt;
   assign hz.FlushCount = flush_cnt;
endmodule
